// File: rtl/pwm_multi_channel.sv
// N-channel PWM core with shadow/active double-buffered registers, edge/center-aligned
// counting and per-channel polarity. Define PWM_IRQ_EN to add the sticky period interrupt.
module pwm_multi_channel #(
    parameter int CH_COUNT = 4,
    parameter int CNT_W    = 16,
    parameter int PRE_W    = 16,
    parameter int ADDR_W   = $clog2(CH_COUNT + 4)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CNT_W-1:0]    cfg_wdata,
    output logic [CH_COUNT-1:0] pwm_out,
    output logic                period_tick,
    output logic [CNT_W-1:0]    cnt_value
`ifdef PWM_IRQ_EN
    ,
    output logic                irq
`endif
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(2);

    logic [CNT_W-1:0]    period_sh, period_act;
    logic [PRE_W-1:0]    pre_sh, pre_act;
    logic                mode_sh, mode_act;
    logic [CH_COUNT-1:0] pol_sh, pol_act;
    logic [CNT_W-1:0]    duty_sh  [CH_COUNT];
    logic [CNT_W-1:0]    duty_act [CH_COUNT];

    logic [PRE_W-1:0]    pre_cnt;
    logic [CNT_W-1:0]    cnt, cnt_next;
    dir_t                dir, dir_next;
    logic                tick, boundary;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_sh <= '0;
            pre_sh    <= '0;
            mode_sh   <= 1'b0;
            pol_sh    <= '0;
            for (int i = 0; i < CH_COUNT; i++) duty_sh[i] <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == ADDR_PERIOD)   period_sh <= cfg_wdata;
            if (cfg_addr == ADDR_PRESCALE) pre_sh    <= PRE_W'(cfg_wdata);
            if (cfg_addr == ADDR_CTRL) begin
                mode_sh <= cfg_wdata[0];
                pol_sh  <= cfg_wdata[CH_COUNT:1];
            end
            for (int i = 0; i < CH_COUNT; i++)
                if (cfg_addr == ADDR_W'(3 + i)) duty_sh[i] <= cfg_wdata;
        end
    end

    assign tick = enable && (pre_cnt == pre_act);

    // In center mode with P=1 the turn at the top already lands on 0, so it is the boundary.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        boundary = 1'b0;
        if (tick) begin
            if (period_act == '0) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else if (!mode_act) begin
                if (cnt >= period_act) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end else if (dir == DIR_UP) begin
                if (cnt >= period_act) begin
                    cnt_next = period_act - CNT_W'(1);
                    if (period_act == CNT_W'(1)) boundary = 1'b1;
                    else                         dir_next = DIR_DOWN;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_next = '0;
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
            pwm_out     <= '0;
            period_act  <= '0;
            pre_act     <= '0;
            mode_act    <= 1'b0;
            pol_act     <= '0;
            for (int i = 0; i < CH_COUNT; i++) duty_act[i] <= '0;
        end else if (!enable) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
            pwm_out     <= pol_sh;
            period_act  <= period_sh;
            pre_act     <= pre_sh;
            mode_act    <= mode_sh;
            pol_act     <= pol_sh;
            for (int i = 0; i < CH_COUNT; i++) duty_act[i] <= duty_sh[i];
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
            cnt         <= cnt_next;
            dir         <= dir_next;
            period_tick <= boundary;
            for (int i = 0; i < CH_COUNT; i++)
                pwm_out[i] <= (cnt < duty_act[i]) ^ pol_act[i];
            if (boundary) begin
                period_act <= period_sh;
                pre_act    <= pre_sh;
                mode_act   <= mode_sh;
                pol_act    <= pol_sh;
                for (int i = 0; i < CH_COUNT; i++) duty_act[i] <= duty_sh[i];
                if (!mode_sh) dir <= DIR_UP;
            end
        end
    end

    assign cnt_value = cnt;

`ifdef PWM_IRQ_EN
    localparam logic [ADDR_W-1:0] ADDR_IRQ_CLR = ADDR_W'(CH_COUNT + 3);

    // A boundary in the same cycle as a clear keeps the interrupt pending.
    always_ff @(posedge clk) begin
        if (!rst_n)                                      irq <= 1'b0;
        else if (boundary)                               irq <= 1'b1;
        else if (cfg_we && (cfg_addr == ADDR_IRQ_CLR))   irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus randomized traffic
// compared every cycle against a period-phase reference model.
module tb_pwm_multi_channel;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int PW = 16;
    localparam int AW = $clog2(CH + 4);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic [CW-1:0] cnt_value;
`ifdef PWM_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .CH_COUNT(CH),
        .CNT_W(CW),
        .PRE_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .cnt_value(cnt_value)
`ifdef PWM_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    // Reference model: configuration plus position in the period (prescale phase, tick index).
    int          sh_p, sh_pre, sh_mode;
    bit [CH-1:0] sh_pol;
    int          sh_duty [CH];
    int          act_p, act_pre, act_mode;
    bit [CH-1:0] act_pol;
    int          act_duty [CH];
    int          m_pre, m_k;
    bit [CH-1:0] exp_pwm;
    bit          exp_tick;
    bit          exp_irq;

    function automatic int plen(input int p, input int m);
        if (p == 0) return 1;
        return (m != 0) ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(input int k, input int p, input int m);
        if (m != 0 && k > p) return 2 * p - k;
        return k;
    endfunction

    task automatic load_active();
        act_p    = sh_p;
        act_pre  = sh_pre;
        act_mode = sh_mode;
        act_pol  = sh_pol;
        act_duty = sh_duty;
    endtask

    task automatic model_update(input bit r, input bit en, input bit we, input int addr, input int wdata);
        bit bnd;
        int c;
        bnd = 1'b0;
        if (!r) begin
            sh_p = 0; sh_pre = 0; sh_mode = 0; sh_pol = '0;
            for (int i = 0; i < CH; i++) sh_duty[i] = 0;
            load_active();
            m_pre = 0; m_k = 0; exp_pwm = '0; exp_tick = 1'b0; exp_irq = 1'b0;
            return;
        end
        if (!en) begin
            exp_pwm  = sh_pol;
            exp_tick = 1'b0;
            m_pre    = 0;
            m_k      = 0;
            load_active();
        end else begin
            c = cnt_of(m_k, act_p, act_mode);
            for (int i = 0; i < CH; i++) exp_pwm[i] = (c < act_duty[i]) ^ act_pol[i];
            exp_tick = 1'b0;
            if (m_pre == act_pre) begin
                m_pre = 0;
                m_k++;
                if (m_k >= plen(act_p, act_mode)) begin
                    m_k = 0;
                    bnd = 1'b1;
                    exp_tick = 1'b1;
                    load_active();
                end
            end else begin
                m_pre++;
            end
        end
`ifdef PWM_IRQ_EN
        if (bnd) exp_irq = 1'b1;
        else if (we && addr == CH + 3) exp_irq = 1'b0;
`endif
        if (we) begin
            if (addr == 0) sh_p = wdata & 16'hFFFF;
            if (addr == 1) sh_pre = wdata & 16'hFFFF;
            if (addr == 2) begin
                sh_mode = wdata & 1;
                sh_pol  = CH'(wdata >> 1);
            end
            if (addr >= 3 && addr < 3 + CH) sh_duty[addr - 3] = wdata & 16'hFFFF;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("pwm_out", {28'b0, pwm_out}, {28'b0, exp_pwm});
        check("period_tick", {31'b0, period_tick}, {31'b0, exp_tick});
        check("cnt_value", {16'b0, cnt_value}, cnt_of(m_k, act_p, act_mode));
`ifdef PWM_IRQ_EN
        check("irq", {31'b0, irq}, {31'b0, exp_irq});
`endif
    endtask

    task automatic apply_stimulus(input bit r, input bit en, input bit we, input int addr, input int wdata);
        rst_n     = r;
        enable    = en;
        cfg_we    = we;
        cfg_addr  = AW'(addr);
        cfg_wdata = CW'(wdata);
        @(posedge clk);
        model_update(r, en, we, addr, wdata);
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic wr(input bit en, input int addr, input int data);
        apply_stimulus(1'b1, en, 1'b1, addr, data);
    endtask

    task automatic measure(input int ch, input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int j = 0; j < n; j++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
            highs += int'(pwm_out[ch]);
            ticks += int'(period_tick);
        end
    endtask

    task automatic wait_tick(input string tag);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
            seen = period_tick;
            n++;
        end
        check(tag, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int h, t;
        rst_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_update(1'b0, 1'b0, 1'b0, 0, 0);

        // Reset with write strobes toggling
        for (int j = 0; j < 3; j++)
            apply_stimulus(1'b0, 1'b0, j[0], $urandom_range(0, 7), $urandom_range(1, 100));
        check("reset_pwm", {28'b0, pwm_out}, 32'd0);

        // Edge mode P=9, PRE=0, DUTY0=3
        wr(1'b0, 0, 9);
        wr(1'b0, 1, 0);
        wr(1'b0, 3, 3);
        wr(1'b0, 2, 0);
        idle(12);
        measure(0, 20, h, t);
        check("edge_high", h, 6);
        check("edge_ticks", t, 2);

        // Mid-period duty write waits for the next boundary
        wait_tick("edge_tick_seen");
        measure(0, 3, h, t);
        check("shadow_old_high", h, 3);
        wr(1'b1, 3, 7);
        measure(0, 6, h, t);
        check("shadow_rest_low", h, 0);
        check("shadow_tick", t, 1);
        measure(0, 10, h, t);
        check("shadow_new_high", h, 7);

        // Center mode P=4, PRE=1, DUTY1=2
        wr(1'b1, 1, 1);
        wr(1'b1, 0, 4);
        wr(1'b1, 4, 2);
        wr(1'b1, 2, 1);
        wait_tick("center_load_tick");
        measure(1, 16, h, t);
        check("center_high", h, 6);
        check("center_ticks", t, 1);

        // Duty limits and polarity on channel 2
        wr(1'b1, 2, 0);
        wr(1'b1, 0, 9);
        wr(1'b1, 1, 0);
        wr(1'b1, 5, 0);
        wait_tick("limit_tick0");
        measure(2, 10, h, t);
        check("duty0_low", h, 0);
        wr(1'b1, 5, 10);
        wait_tick("limit_tick1");
        measure(2, 10, h, t);
        check("duty_full_high", h, 10);
        wr(1'b1, 2, 8);
        wait_tick("limit_tick2");
        measure(2, 10, h, t);
        check("pol_full_low", h, 0);
        wr(1'b1, 5, 0);
        wait_tick("limit_tick3");
        measure(2, 10, h, t);
        check("pol_zero_high", h, 10);
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
        check("disabled_pol", {28'b0, pwm_out}, 32'h4);

`ifdef PWM_IRQ_EN
        // Interrupt set, clear, and clear colliding with a boundary
        wr(1'b0, 2, 0);
        wait_tick("irq_tick");
        check("irq_set", {31'b0, irq}, 32'd1);
        wr(1'b1, CH + 3, 0);
        check("irq_clr", {31'b0, irq}, 32'd0);
        idle(8);
        wr(1'b1, CH + 3, 0);
        check("irq_clr_on_boundary_tick", {31'b0, period_tick}, 32'd1);
        check("irq_clr_on_boundary", {31'b0, irq}, 32'd1);
`endif

        // Randomized configuration traffic with enable toggles and rare resets
        for (int j = 0; j < 600; j++) begin
            int  a, d;
            bit  r, en, we;
            r  = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 29) != 0);
            we = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, 7);
            case (a)
                0:       d = $urandom_range(0, 6);
                1:       d = $urandom_range(0, 2);
                2:       d = $urandom_range(0, 31);
                default: d = $urandom_range(0, 8);
            endcase
            apply_stimulus(r, en, we, a, d);
        end

        // Reset in the middle of a running period
        wr(1'b0, 0, 9);
        wr(1'b0, 1, 0);
        wr(1'b0, 3, 5);
        wr(1'b0, 2, 2);
        idle(14);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0);
        check("midreset_pwm", {28'b0, pwm_out}, 32'd0);
        check("midreset_cnt", {16'b0, cnt_value}, 32'd0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
